// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU op-code constants and op legality helper
//
// Purpose : op-code encodings shared by the ALU and its arbiter, plus
//           is_legal_op() which flags the two unassigned encodings (010, 011).
// Ports   : none (package)
package alu_arbiter_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;  // ext=1 selects subtract
    localparam logic [OP_W-1:0] OP_SLL = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SR  = 3'b101;  // ext=1 selects arithmetic shift
    localparam logic [OP_W-1:0] OP_OR  = 3'b110;
    localparam logic [OP_W-1:0] OP_AND = 3'b111;

    function automatic logic is_legal_op(input logic [OP_W-1:0] s);
        case (s)
            OP_ADD, OP_SLL, OP_XOR, OP_SR, OP_OR, OP_AND: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rtl/alu_arbiter_rr_arbiter.sv - generic round-robin one-hot grant generator
//
// Purpose : grants the first set request bit at or above ptr, wrapping modulo N.
// Ports   : i_req [N-1:0]  request vector
//           i_ptr [PW-1:0] highest-priority index (must be < N)
//           o_gnt [N-1:0]  one-hot grant, zero when no request
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_req_rot;
    logic [N-1:0]   w_oh_rot;
    logic [2*N-1:0] w_oh_dbl;

    // Rotate requests so that ptr lands at bit 0; a doubled vector makes the
    // wrap free and avoids any variable bit indexing.
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = w_req_dbl >> i_ptr;

    // Fixed priority on the rotated vector: lowest offset wins.
    always_comb begin
        w_oh_rot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_oh_rot    = '0;
                w_oh_rot[k] = 1'b1;
            end
        end
    end

    // Rotate the one-hot back into requester numbering.
    assign w_oh_dbl = {w_oh_rot, w_oh_rot} << i_ptr;
    assign o_gnt    = w_oh_dbl[2*N-1:N];

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU with a one-entry response slot
//
// Purpose : arbitrates NREQ requesters onto the ALU operand bus and registers
//           the ALU result into a valid/ready response slot.
// Ports   : clk, rst_n                      clock, async active-low reset
//           req_valid/req_ready             per-requester handshake
//           req_a/req_b/req_s/req_ext       packed per-requester operands
//           alu_a/alu_b/alu_s/alu_ext/alu_y ALU bus (alu_y is combinational)
//           rsp_valid/rsp_ready/rsp_y/rsp_id/rsp_err  response slot
// Option  : ALU_ARB_STATS_EN adds stat_grants (per-requester saturating
//           16-bit grant counters) and stat_stall (saturating stall count).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP     = 3,
    parameter int NREQ   = 2,
    parameter int ID_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*OP-1:0]   req_s,
    input  logic [NREQ-1:0]      req_ext,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OP-1:0]        alu_s,
    output logic                 alu_ext,
    input  logic [DATA_W-1:0]    alu_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_y,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_grants,
    output logic [15:0]          stat_stall
`endif
);

    logic [ID_W-1:0]   r_rr;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_y;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_err;

    logic [NREQ-1:0]   w_gnt;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W-1:0]   w_rr_next;
    logic              w_slot_free;
    logic              w_accept;

    rr_arbiter #(
        .N  (NREQ),
        .PW (ID_W)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_rr),
        .o_gnt (w_gnt)
    );

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    // rst_n gates ready so nothing is accepted while reset is asserted.
    assign req_ready   = w_gnt & {NREQ{w_slot_free && rst_n}};
    assign w_accept    = |req_ready;

    // Grant index and operand mux; all zero when nothing is granted.
    always_comb begin
        w_gnt_idx = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_s     = '0;
        alu_ext   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = ID_W'(i);
                alu_a     = req_a[i*DATA_W +: DATA_W];
                alu_b     = req_b[i*DATA_W +: DATA_W];
                alu_s     = req_s[i*OP +: OP];
                alu_ext   = req_ext[i];
            end
        end
    end

    assign w_rr_next = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            // Covers the drain-and-reload case: the slot simply stays valid.
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= alu_y;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_err   <= !is_legal_op(3'(alu_s));
            r_rr        <= w_rr_next;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grants [NREQ];
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) r_grants[i] <= '0;
            r_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_valid[i] && r_grants[i] != 16'hFFFF)
                    r_grants[i] <= r_grants[i] + 16'd1;
            end
            if (r_rsp_valid && !rsp_ready && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = r_grants[g];
    end
    assign stat_stall = r_stall;
`endif

endmodule
